// File: rtl/can_rx_frame_fifo.sv
// Assembles byte-serial CAN receive beats into fixed-format frame records and
// queues them in a first-word-fall-through FIFO with overflow accounting.
module can_rx_frame_fifo #(
  parameter int ADDR_W = 2,
  parameter int OVF_W  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_last,
  input  logic [28:0]       rx_id,
  input  logic              rx_ide,
  input  logic              clr_ovf,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [28:0]       frm_id,
  output logic              frm_ide,
  output logic [3:0]        frm_len,
  output logic [31:0]       frm_data_hi,
  output logic [31:0]       frm_data_lo,
  output logic              frm_trunc,
  output logic [ADDR_W:0]   fifo_count,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              ovf_flag,
  output logic              int_wire
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  // Assembly state
  logic [3:0]  bcnt;
  logic [63:0] asm_data;
  logic [28:0] asm_id;
  logic        asm_ide;
  logic        trunc_pend;

  // Record as it would look with the current beat folded in
  logic [63:0] asm_next;
  logic [28:0] rec_id;
  logic        rec_ide;
  logic [3:0]  rec_len;
  logic        rec_trunc;

  // FIFO state
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [28:0]       mem_id    [DEPTH];
  logic              mem_ide   [DEPTH];
  logic [3:0]        mem_len   [DEPTH];
  logic [63:0]       mem_data  [DEPTH];
  logic              mem_trunc [DEPTH];

  logic frame_end;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Byte index i lands at bits [63-8i -: 8], so byte0 is the MSB of data_hi.
  always_comb begin
    asm_next = asm_data;
    for (int i = 0; i < 8; i++) begin
      if (rx_valid && bcnt == 4'(i)) asm_next[63-8*i -: 8] = rx_data;
    end
    rec_id    = (bcnt == 4'd0) ? rx_id  : asm_id;
    rec_ide   = (bcnt == 4'd0) ? rx_ide : asm_ide;
    rec_len   = (bcnt < 4'd8) ? bcnt + 4'd1 : 4'd8;
    rec_trunc = trunc_pend | (bcnt == 4'd8);
  end

  assign wr_ptr     = wr_cnt[ADDR_W-1:0];
  assign rd_ptr     = rd_cnt[ADDR_W-1:0];
  assign fifo_count = wr_cnt - rd_cnt;
  assign full       = (fifo_count == FULL_CNT);
  assign frm_valid  = (wr_cnt != rd_cnt);
  assign int_wire   = frm_valid;
  assign frame_end  = rx_valid & rx_last;
  assign pop        = frm_valid & frm_ready;
  assign push       = frame_end & (~full | pop);
  assign drop       = frame_end & full & ~pop;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bcnt       <= 4'd0;
      asm_data   <= 64'd0;
      asm_id     <= 29'd0;
      asm_ide    <= 1'b0;
      trunc_pend <= 1'b0;
    end else if (frame_end) begin
      bcnt       <= 4'd0;
      asm_data   <= 64'd0;
      asm_id     <= 29'd0;
      asm_ide    <= 1'b0;
      trunc_pend <= 1'b0;
    end else if (rx_valid) begin
      asm_data   <= asm_next;
      asm_id     <= rec_id;
      asm_ide    <= rec_ide;
      trunc_pend <= rec_trunc;
      bcnt       <= rec_len;
    end
  end

  // Storage needs no reset: head fields are masked while the FIFO is empty.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_id[wr_ptr]    <= rec_id;
      mem_ide[wr_ptr]   <= rec_ide;
      mem_len[wr_ptr]   <= rec_len;
      mem_data[wr_ptr]  <= asm_next;
      mem_trunc[wr_ptr] <= rec_trunc;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // A clear in the same cycle as a drop is applied first, leaving a count of one.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      if (clr_ovf)        ovf_cnt <= OVF_W'(1);
      else if (~&ovf_cnt) ovf_cnt <= ovf_cnt + 1'b1;
    end else if (clr_ovf) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end
  end

  assign frm_id      = frm_valid ? mem_id[rd_ptr]           : 29'd0;
  assign frm_ide     = frm_valid ? mem_ide[rd_ptr]          : 1'b0;
  assign frm_len     = frm_valid ? mem_len[rd_ptr]          : 4'd0;
  assign frm_data_hi = frm_valid ? mem_data[rd_ptr][63:32]  : 32'd0;
  assign frm_data_lo = frm_valid ? mem_data[rd_ptr][31:0]   : 32'd0;
  assign frm_trunc   = frm_valid ? mem_trunc[rd_ptr]        : 1'b0;

endmodule

// File: tb/tb_can_rx_frame_fifo.sv
// Directed self-checking bench for can_rx_frame_fifo (ADDR_W=2, OVF_W=8).
module tb_can_rx_frame_fifo;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        clr_ovf;
  logic        frm_valid;
  logic        frm_ready;
  logic [28:0] frm_id;
  logic        frm_ide;
  logic [3:0]  frm_len;
  logic [31:0] frm_data_hi;
  logic [31:0] frm_data_lo;
  logic        frm_trunc;
  logic [2:0]  fifo_count;
  logic [7:0]  ovf_cnt;
  logic        ovf_flag;
  logic        int_wire;

  int checks   = 0;
  int failures = 0;
  logic [7:0] tx_bytes [16];

  can_rx_frame_fifo #(.ADDR_W(2), .OVF_W(8)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_id(rx_id), .rx_ide(rx_ide), .clr_ovf(clr_ovf),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_id(frm_id),
    .frm_ide(frm_ide), .frm_len(frm_len), .frm_data_hi(frm_data_hi),
    .frm_data_lo(frm_data_lo), .frm_trunc(frm_trunc),
    .fifo_count(fifo_count), .ovf_cnt(ovf_cnt), .ovf_flag(ovf_flag),
    .int_wire(int_wire)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends n bytes from tx_bytes; id/ide are presented on every beat, but only the first should be used.
  task automatic applyStimulus(input logic [28:0] id, input logic ide, input int n,
                               input logic with_last);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = tx_bytes[i];
      rx_last  = with_last && (i == n - 1);
      rx_id    = (i == 0) ? id : 29'h0ABCDEF;
      rx_ide   = (i == 0) ? ide : ~ide;
      @(posedge ap_clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic popFrame();
    frm_ready = 1'b1;
    @(posedge ap_clk); #1;
    frm_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ap_clk); #1;
    end
  endtask

  initial begin
    ap_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
    rx_id = 29'd0; rx_ide = 1'b0; clr_ovf = 1'b0; frm_ready = 1'b0;
    idle(3);
    checkOutput("rst_valid", frm_valid, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_ovf_cnt", ovf_cnt, 0);
    checkOutput("rst_ovf_flag", ovf_flag, 0);
    checkOutput("rst_int", int_wire, 0);
    checkOutput("rst_data", {frm_data_hi, frm_data_lo}, 0);
    ap_rst = 1'b0;
    idle(1);

    $display("[TB] 8-byte frame");
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'((i + 1) * 8'h11);
    applyStimulus(29'h003, 1'b0, 7, 1'b0);
    checkOutput("a_valid_before_last", frm_valid, 0);
    tx_bytes[0] = 8'h88;
    applyStimulus(29'h1FFFFFFF, 1'b1, 1, 1'b1);
    checkOutput("a_valid", frm_valid, 1);
    checkOutput("a_int", int_wire, 1);
    checkOutput("a_hi", frm_data_hi, 64'h11223344);
    checkOutput("a_lo", frm_data_lo, 64'h55667788);
    checkOutput("a_len", frm_len, 8);
    checkOutput("a_trunc", frm_trunc, 0);
    checkOutput("a_id", frm_id, 29'h003);
    checkOutput("a_ide", frm_ide, 0);
    idle(2);
    checkOutput("a_hold_hi", frm_data_hi, 64'h11223344);
    popFrame();
    checkOutput("a_popped_valid", frm_valid, 0);
    checkOutput("a_popped_int", int_wire, 0);

    $display("[TB] 3-byte extended frame");
    tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC;
    applyStimulus(29'h12345678, 1'b1, 3, 1'b1);
    checkOutput("b_hi", frm_data_hi, 64'hAABBCC00);
    checkOutput("b_lo", frm_data_lo, 0);
    checkOutput("b_len", frm_len, 3);
    checkOutput("b_id", frm_id, 29'h12345678);
    checkOutput("b_ide", frm_ide, 1);
    popFrame();

    $display("[TB] 10-byte truncated frame then 2-byte frame");
    for (int i = 0; i < 10; i++) tx_bytes[i] = 8'(i + 1);
    applyStimulus(29'h7FF, 1'b0, 10, 1'b1);
    checkOutput("c_len", frm_len, 8);
    checkOutput("c_trunc", frm_trunc, 1);
    checkOutput("c_hi", frm_data_hi, 64'h01020304);
    checkOutput("c_lo", frm_data_lo, 64'h05060708);
    tx_bytes[0] = 8'hD1; tx_bytes[1] = 8'hD2;
    applyStimulus(29'h055, 1'b0, 2, 1'b1);
    checkOutput("c_count", fifo_count, 2);
    popFrame();
    checkOutput("d_len", frm_len, 2);
    checkOutput("d_trunc", frm_trunc, 0);
    checkOutput("d_hi", frm_data_hi, 64'hD1D20000);
    checkOutput("d_lo", frm_data_lo, 0);
    checkOutput("d_id", frm_id, 29'h055);
    popFrame();

    $display("[TB] overflow with five 1-byte frames");
    for (int i = 1; i <= 5; i++) begin
      tx_bytes[0] = 8'(i);
      applyStimulus(29'(i), 1'b0, 1, 1'b1);
    end
    checkOutput("e_count", fifo_count, 4);
    checkOutput("e_ovf_cnt", ovf_cnt, 1);
    checkOutput("e_ovf_flag", ovf_flag, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("e_order_hi", frm_data_hi, {32'd0, 8'(i), 24'd0});
      checkOutput("e_order_id", frm_id, 64'(i));
      checkOutput("e_order_len", frm_len, 1);
      popFrame();
    end
    checkOutput("e_empty", frm_valid, 0);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    checkOutput("e_clr_cnt", ovf_cnt, 0);
    checkOutput("e_clr_flag", ovf_flag, 0);

    $display("[TB] push and pop together when full");
    for (int i = 0; i < 4; i++) begin
      tx_bytes[0] = 8'h10 + 8'(i);
      applyStimulus(29'h100 + 29'(i), 1'b0, 1, 1'b1);
    end
    checkOutput("f_full", fifo_count, 4);
    tx_bytes[0] = 8'h14;
    frm_ready = 1'b1;
    applyStimulus(29'h104, 1'b0, 1, 1'b1);
    frm_ready = 1'b0;
    checkOutput("f_count", fifo_count, 4);
    checkOutput("f_ovf_cnt", ovf_cnt, 0);
    checkOutput("f_ovf_flag", ovf_flag, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("f_order", frm_data_hi, {32'd0, 8'h10 + 8'(i), 24'd0});
      popFrame();
    end
    checkOutput("f_empty", fifo_count, 0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h60 + 8'(i);
    applyStimulus(29'h0BAD, 1'b0, 4, 1'b0);
    ap_rst = 1'b1; idle(1); ap_rst = 1'b0; idle(1);
    tx_bytes[0] = 8'hE1; tx_bytes[1] = 8'hE2;
    applyStimulus(29'h1ABCDEF0, 1'b1, 2, 1'b1);
    checkOutput("g_count", fifo_count, 1);
    checkOutput("g_len", frm_len, 2);
    checkOutput("g_id", frm_id, 29'h1ABCDEF0);
    checkOutput("g_ide", frm_ide, 1);
    checkOutput("g_hi", frm_data_hi, 64'hE1E20000);
    checkOutput("g_lo", frm_data_lo, 0);

    $display("[TB] clear coinciding with drop");
    for (int i = 0; i < 5; i++) begin
      tx_bytes[0] = 8'h70 + 8'(i);
      applyStimulus(29'h200, 1'b0, 1, 1'b1);
    end
    checkOutput("h_ovf_two", ovf_cnt, 2);
    clr_ovf = 1'b1;
    tx_bytes[0] = 8'h7F;
    applyStimulus(29'h201, 1'b0, 1, 1'b1);
    clr_ovf = 1'b0;
    checkOutput("h_ovf_cnt", ovf_cnt, 1);
    checkOutput("h_ovf_flag", ovf_flag, 1);
    checkOutput("h_head_kept", frm_data_hi, 64'hE1E20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
